butterfly_pipe: RTL and testbench

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

---
 rtl/butterfly_pipe.sv | 186 ++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pipe.sv
// Pipelined NTT butterfly and modular ALU over Z_Q.
// Mode rides with each beat; one global stall enable moves every stage.
module butterfly_pipe #(
  parameter int W          = 24,
  parameter int Q          = 8380417,
  parameter int MUL_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_mode,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_zeta,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [2:0]   out_mode,
  output logic         err,
  input  logic         err_clr
);
  localparam int M = MUL_STAGES;
  localparam logic [W-1:0] QV = W'(Q);
  localparam logic [W-1:0] HQ = W'((Q + 1) / 2);
  localparam logic [2:0] M_FWD = 3'd0;
  localparam logic [2:0] M_INV = 3'd1;
  localparam logic [2:0] M_MAC = 3'd2;
  localparam logic [2:0] M_ADD = 3'd3;
  localparam logic [2:0] M_SUB = 3'd4;

  typedef struct packed {
    logic [2:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
  } s1_t;

  typedef struct packed {
    logic [2:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } car_t;

  function automatic logic [W-1:0] add_q(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, QV}) s = s - {1'b0, QV};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_q(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[W]) d = d + {1'b0, QV};
    return d[W-1:0];
  endfunction

  // Multiply by 2^-1: odd values borrow (Q+1)/2.
  function automatic logic [W-1:0] half_q(input logic [W-1:0] x);
    return x[0] ? (x >> 1) + HQ : x >> 1;
  endfunction

  logic         adv;
  logic         acc;
  logic         bad;
  logic         v1;
  logic         v2;
  logic         vo;
  logic [M-1:0] mv;

  s1_t          s1;
  car_t         s2;
  car_t         mc [M];
  logic [W-1:0] pre_x;
  logic [W-1:0] pre_y;
  logic [W-1:0] pre_r;
  logic [W-1:0] x2;
  logic [W-1:0] y2;
  logic [2*W-1:0] mp [M];
  logic [W-1:0] red;
  car_t         c;
  logic [W-1:0] oa;
  logic [W-1:0] ob;

  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = vo;
  assign acc       = in_valid && adv;
  assign bad       = acc && (in_mode > M_SUB || in_a >= QV ||
                             in_b >= QV || in_zeta >= QV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      mv <= '0;
      vo <= 1'b0;
    end else if (adv) begin
      v1    <= in_valid;
      v2    <= v1;
      mv[0] <= v2;
      for (int i = 1; i < M; i++) mv[i] <= mv[i-1];
      vo    <= mv[M-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (bad)     err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  always_comb begin
    pre_x = s1.b;
    pre_y = s1.z;
    pre_r = s1.b;
    unique case (1'b1)
      s1.mode == M_INV: begin
        pre_x = sub_q(s1.a, s1.b);
        pre_y = QV - s1.z;
        pre_r = half_q(add_q(s1.a, s1.b));
      end
      s1.mode == M_ADD: pre_r = add_q(s1.b, s1.z);
      s1.mode == M_SUB: pre_r = sub_q(s1.b, s1.z);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1    <= '{in_mode, in_a, in_b, in_zeta};
      s2    <= '{s1.mode, s1.a, s1.b, pre_r};
      x2    <= pre_x;
      y2    <= pre_y;
      mp[0] <= {{W{1'b0}}, x2} * {{W{1'b0}}, y2};
      mc[0] <= s2;
      for (int i = 1; i < M; i++) begin
        mp[i] <= mp[i-1];
        mc[i] <= mc[i-1];
      end
    end
  end

  assign red = W'(mp[M-1] % {{W{1'b0}}, QV});
  assign c   = mc[M-1];

  always_comb begin
    oa = c.a;
    ob = c.b;
    unique case (1'b1)
      c.mode == M_FWD: begin
        oa = add_q(c.a, red);
        ob = sub_q(c.a, red);
      end
      c.mode == M_INV: begin
        oa = c.r;
        ob = half_q(red);
      end
      c.mode == M_MAC: ob = add_q(red, c.a);
      c.mode == M_ADD || c.mode == M_SUB: ob = c.r;
      default: ;
    endcase
  end

  // Output data only moves on real beats so it reads 0 until the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a    <= '0;
      out_b    <= '0;
      out_mode <= '0;
    end else if (adv && mv[M-1]) begin
      out_a    <= oa;
      out_b    <= ob;
      out_mode <= c.mode;
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Randomized bench for butterfly_pipe.
// Results are checked against a plain modular-arithmetic model.
module tb_butterfly_pipe;
  localparam int W  = 24;
  localparam int Q  = 8380417;
  localparam int MS = 2;
  localparam int L  = MS + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_mode = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] in_zeta = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [2:0]   out_mode;
  logic         err;
  logic         err_clr = 1'b0;

  typedef struct {
    logic [2:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           c;
  } beat_t;

  beat_t  exp_q[$];
  beat_t  got_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  longint mon_ea;
  longint mon_eb;

  butterfly_pipe #(.W(W), .Q(Q), .MUL_STAGES(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
    .in_zeta(in_zeta),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_mode(out_mode),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(
    input  logic [2:0] m,
    input  longint a, input longint b, input longint z,
    output longint ea, output longint eb
  );
    longint i2;
    longint t;
    i2 = (Q + 1) / 2;
    t  = (b * z) % Q;
    ea = a;
    eb = b;
    case (m)
      3'd0: begin
        ea = (a + t) % Q;
        eb = (a - t + Q) % Q;
      end
      3'd1: begin
        ea = (((a + b) % Q) * i2) % Q;
        eb = ((((a - b + Q) % Q) * ((Q - z) % Q)) % Q * i2) % Q;
      end
      3'd2: eb = (t + a) % Q;
      3'd3: eb = (b + z) % Q;
      3'd4: eb = (b - z + Q) % Q;
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      got_q.push_back('{out_mode, out_a, out_b, cyc});
    if (rst_n && in_valid && in_ready) begin
      model(in_mode, longint'(in_a), longint'(in_b),
            longint'(in_zeta), mon_ea, mon_eb);
      exp_q.push_back('{in_mode, W'(mon_ea), W'(mon_eb), cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] m, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] z);
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    in_zeta  = z;
  endtask

  task automatic flush();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (L + 2) tick();
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(0, Q - 1));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    #3;
    checks += 5;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", out_valid);
    end
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", err);
    end
    if (out_a !== '0) begin
      errors++; $display("FAIL reset_a got %0d want 0", out_a);
    end
    if (out_b !== '0) begin
      errors++; $display("FAIL reset_b got %0d want 0", out_b);
    end
    if (out_mode !== '0) begin
      errors++; $display("FAIL reset_mode got %0d want 0", out_mode);
    end
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_fwd_vector();
    int k;
    flush();
    put(3'd0, 24'd1, 24'd2, 24'd3);
    tick();
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    checks += 4;
    if (k != L) begin
      errors++; $display("FAIL fwd_latency got %0d want %0d", k, L);
    end
    if (out_a !== 24'd7) begin
      errors++; $display("FAIL fwd_a got %0d want 7", out_a);
    end
    if (out_b !== 24'd8380412) begin
      errors++; $display("FAIL fwd_b got %0d want 8380412", out_b);
    end
    if (out_mode !== 3'd0) begin
      errors++; $display("FAIL fwd_mode got %0d want 0", out_mode);
    end
  endtask

  task automatic test_inv_vectors();
    flush();
    put(3'd1, 24'd3, 24'd1, 24'd1);
    tick();
    put(3'd1, 24'd1, 24'd0, 24'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && got_q.size() < 2; i++) tick();
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL inv_count got %0d want 2", got_q.size());
    end else begin
      checks += 4;
      if (got_q[0].a !== 24'd2) begin
        errors++; $display("FAIL inv0_a got %0d want 2", got_q[0].a);
      end
      if (got_q[0].b !== 24'd8380416) begin
        errors++; $display("FAIL inv0_b got %0d want 8380416", got_q[0].b);
      end
      if (got_q[1].a !== 24'd4190209) begin
        errors++; $display("FAIL inv1_a got %0d want 4190209", got_q[1].a);
      end
      if (got_q[1].b !== 24'd0) begin
        errors++; $display("FAIL inv1_b got %0d want 0", got_q[1].b);
      end
    end
  endtask

  task automatic test_mixed_stream();
    flush();
    put(3'd0, rnd(), rnd(), rnd());
    tick();
    put(3'd2, 24'd5, W'(Q - 1), 24'd2);
    tick();
    put(3'd3, rnd(), W'(Q - 1), 24'd1);
    tick();
    put(3'd4, rnd(), 24'd0, 24'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && got_q.size() < 4; i++) tick();
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL mix_count got %0d want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (got_q[i].m !== exp_q[i].m || got_q[i].a !== exp_q[i].a) begin
          errors++;
          $display("FAIL mix_a[%0d] got m%0d/%0d want m%0d/%0d", i,
                   got_q[i].m, got_q[i].a, exp_q[i].m, exp_q[i].a);
        end
        if (got_q[i].b !== exp_q[i].b) begin
          errors++;
          $display("FAIL mix_b[%0d] got %0d want %0d", i,
                   got_q[i].b, exp_q[i].b);
        end
        if (got_q[i].c != got_q[0].c + i) begin
          errors++;
          $display("FAIL mix_cycle[%0d] got %0d want %0d", i,
                   got_q[i].c, got_q[0].c + i);
        end
      end
      checks += 3;
      if (got_q[1].b !== 24'd3) begin
        errors++; $display("FAIL mac_b got %0d want 3", got_q[1].b);
      end
      if (got_q[2].b !== 24'd0) begin
        errors++; $display("FAIL add_b got %0d want 0", got_q[2].b);
      end
      if (got_q[3].b !== 24'd8380416) begin
        errors++; $display("FAIL sub_b got %0d want 8380416", got_q[3].b);
      end
    end
  endtask

  task automatic test_random_stall();
    logic [2:0]   bm [8];
    logic [W-1:0] ba [8];
    logic [W-1:0] bb [8];
    logic [W-1:0] bz [8];
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic [2:0]   pm;
    logic hold;
    logic acc;
    int sent;
    int c;
    int stalls;
    flush();
    for (int i = 0; i < 8; i++) begin
      bm[i] = 3'($urandom_range(0, 4));
      ba[i] = rnd();
      bb[i] = rnd();
      bz[i] = rnd();
    end
    sent = 0;
    c = 0;
    stalls = 0;
    hold = 1'b0;
    pa = '0; pb = '0; pm = '0;
    while ((sent < 8 || got_q.size() < 8) && c < 200) begin
      if (sent < 8) put(bm[sent], ba[sent], bb[sent], bz[sent]);
      else in_valid = 1'b0;
      out_ready = !(c >= 6 && c < 11);
      @(negedge clk);
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL stall_ready c%0d got %b want %b", c,
                 in_ready, !(out_valid && !out_ready));
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_a !== pa ||
            out_b !== pb || out_mode !== pm) begin
          errors++;
          $display("FAIL stall_hold c%0d got %0d/%0d want %0d/%0d",
                   c, out_a, out_b, pa, pb);
        end
      end
      hold = out_valid && !out_ready;
      if (hold) stalls++;
      pa = out_a;
      pb = out_b;
      pm = out_mode;
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks += 2;
    if (stalls != 5) begin
      errors++; $display("FAIL stall_cycles got %0d want 5", stalls);
    end
    if (got_q.size() != 8 || exp_q.size() != 8) begin
      errors++;
      $display("FAIL stall_count got %0d want 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i].m !== exp_q[i].m || got_q[i].a !== exp_q[i].a ||
            got_q[i].b !== exp_q[i].b) begin
          errors++;
          $display("FAIL stall_beat[%0d] got m%0d %0d/%0d want m%0d %0d/%0d",
                   i, got_q[i].m, got_q[i].a, got_q[i].b,
                   exp_q[i].m, exp_q[i].a, exp_q[i].b);
        end
      end
    end
  endtask

  task automatic test_err();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    flush();
    put(3'd3, W'(Q), 24'd0, 24'd0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_set got %b want 1", err);
    end
    repeat (3) tick();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b want 1", err);
    end
    for (int i = 0; i < 20 && got_q.size() < 1; i++) tick();
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL err_delivered got %0d want 1", got_q.size());
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b want 0", err);
    end
    err_clr = 1'b1;
    put(3'd4, 24'd0, 24'd0, W'(Q));
    tick();
    err_clr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_set_wins got %b want 1", err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    flush();
    ra = rnd();
    rb = rnd();
    put(3'd6, ra, rb, rnd());
    tick();
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_reserved got %b want 1", err);
    end
    for (int i = 0; i < 20 && got_q.size() < 1; i++) tick();
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL rsv_count got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].a !== ra || got_q[0].b !== rb || got_q[0].m !== 3'd6) begin
        errors++;
        $display("FAIL rsv_pass got m%0d %0d/%0d want m6 %0d/%0d",
                 got_q[0].m, got_q[0].a, got_q[0].b, ra, rb);
      end
    end
  endtask

  task automatic test_async_reset();
    flush();
    out_ready = 1'b0;
    put(3'd3, W'(Q), rnd(), rnd());
    tick();
    put(3'd0, rnd(), rnd(), rnd());
    tick();
    put(3'd2, rnd(), rnd(), rnd());
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < L + 3 && !out_valid; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got v%b e%b want v1 e1", out_valid, err);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL arst_drop got v%b e%b want v0 e0", out_valid, err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b1;
    repeat (L + 5) tick();
    checks++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_discard got %0d beats want 0", got_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fwd_vector();
    test_inv_vectors();
    test_mixed_stream();
    test_random_stall();
    test_err();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
